// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and constants for the neuron accumulation path
//
// Purpose: datapath width, saturation ceiling and the accumulator FSM state type.
// Ports:   none (package).
package neuron_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } accum_state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 16-bit unsigned ripple-carry adder
//
// Purpose: combinational sum of two unsigned 16-bit operands with carry out.
// Ports:
//   in1, in2  in  16  operands
//   sum       out 16  in1 + in2, truncated to 16 bits
//   carry     out 1   carry out of bit 15
module adder (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  output logic [15:0] sum,
  output logic        carry
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1]   = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end

  assign carry = c[16];

endmodule

// File: rtl/neuron_accum_ctrl.sv
// rtl/neuron_accum_ctrl.sv - bias plus N streamed products, saturating accumulator controller
//
// Purpose: loads a bias on start, adds N_INPUTS product beats through the shared
//          ripple adder with unsigned saturation, then holds the result until taken.
// Ports:
//   clk        in  1   rising-edge clock
//   rst        in  1   asynchronous active-high reset
//   start      in  1   begin accumulation (IDLE only)
//   bias       in  16  initial accumulator value, sampled with start
//   clear      in  1   synchronous abort to IDLE, highest priority
//   in_valid   in  1   product beat valid
//   in_data    in  16  product value
//   in_ready   out 1   beat accepted this cycle (ACCUM)
//   out_valid  out 1   result presented (DONE)
//   out_data   out 16  saturated sum
//   out_ovf    out 1   at least one add carried out
//   out_ready  in  1   downstream takes the result
//   busy       out 1   not IDLE
module neuron_accum_ctrl
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  accum_state_t      state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf, ovf_nxt;

  logic [DATA_W-1:0] add_sum;
  logic              add_carry;

  // The adder runs every cycle on acc + in_data; its result is only used on a beat.
  adder u_adder (
    .in1   (acc),
    .in2   (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;

    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ACCUM;
            acc_nxt   = bias;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            // A carry means the true sum exceeded 16 bits; pin at the ceiling.
            // Once pinned, every further add either carries or adds zero,
            // so acc stays at SAT_MAX without extra logic.
            acc_nxt = add_carry ? SAT_MAX : add_sum;
            ovf_nxt = ovf | add_carry;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Outputs decode only from registered state, so no input reaches an output
  // combinationally.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = (state == DONE) ? acc : '0;
  assign out_ovf   = (state == DONE) & ovf;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// tb/tb_neuron_accum_ctrl.sv - directed scoreboard bench for neuron_accum_ctrl
module tb_neuron_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, clear, in_valid, out_ready;
  logic [15:0] bias, in_data;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_data;

  logic        start1, clear1, in_valid1, out_ready1;
  logic [15:0] bias1, in_data1;
  logic        in_ready1, out_valid1, out_ovf1, busy1;
  logic [15:0] out_data1;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  neuron_accum_ctrl #(.N_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
    .out_ready(out_ready), .busy(busy)
  );

  neuron_accum_ctrl #(.N_INPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bias(bias1), .clear(clear1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ovf(out_ovf1),
    .out_ready(out_ready1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 17-bit add, saturate on carry, sticky overflow.
  task automatic push_exp(input logic [15:0] b, input logic [15:0] x0, x1, x2, x3, input int n);
    logic [15:0] acc;
    logic        ovf;
    logic [16:0] s;
    logic [15:0] xs [4];
    xs  = '{x0, x1, x2, x3};
    acc = b;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, acc} + {1'b0, xs[i]};
      if (s[16]) begin
        acc = 16'hFFFF;
        ovf = 1'b1;
      end else begin
        acc = s[15:0];
      end
    end
    exp_q.push_back({ovf, acc});
  endtask

  task automatic do_start(input logic [15:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed4(input logic [15:0] x0, x1, x2, x3, input bit gap);
    logic [15:0] xs [4];
    xs = '{x0, x1, x2, x3};
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = xs[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard head,
  // optionally stall out_ready for some cycles, then take the result.
  task automatic collect(input string tag, input int stall);
    logic [16:0] e;
    int          k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, {16'd0, out_data}, {16'd0, e[15:0]});
      chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e[16]});
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_stall_data"}, {16'd0, out_data}, {16'd0, e[15:0]});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = 16'h0; in_data = 16'h0;
    start1 = 1'b0; clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    bias1 = 16'h0; in_data1 = 16'h0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Beats offered in IDLE are refused.
    in_valid = 1'b1;
    in_data  = 16'h0055;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Test 1: bias 10 + 1,2,3,4, back-to-back, latency check.
    push_exp(16'd10, 16'd1, 16'd2, 16'd3, 16'd4, 4);
    do_start(16'd10);
    chk("t1_in_ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    feed4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    chk("t1_valid_after_last", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready_done", {31'd0, in_ready}, 32'd0);
    collect("t1", 0);

    // Test 2: saturation on the second beat.
    push_exp(16'hFFF0, 16'h0008, 16'h0010, 16'd5, 16'd0, 4);
    do_start(16'hFFF0);
    feed4(16'h0008, 16'h0010, 16'd5, 16'd0, 1'b0);
    collect("t2", 0);

    // Test 3: gapped input and a 3-cycle output stall.
    push_exp(16'd10, 16'd1, 16'd2, 16'd3, 16'd4, 4);
    do_start(16'd10);
    feed4(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    collect("t3", 3);

    // Test 4: clear after two beats, then clear+start together.
    do_start(16'd200);
    in_valid = 1'b1; in_data = 16'd1;
    @(negedge clk);
    in_data = 16'd2;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t4_clr_busy", {31'd0, busy}, 32'd0);
    chk("t4_clr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_clr_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_result", {31'd0, out_valid}, 32'd0);
    end
    start = 1'b1; clear = 1'b1; bias = 16'd77;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("t4_clr_start_busy", {31'd0, busy}, 32'd0);
    push_exp(16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 4);
    do_start(16'd0);
    feed4(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    collect("t4", 0);

    // Test 5a: reset mid-accumulation.
    do_start(16'd50);
    in_valid = 1'b1; in_data = 16'd9;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", {16'd0, out_data}, 32'd0);
    chk("t5_rst_ovf", {31'd0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 5b: start in ACCUM and DONE ignored, bias not resampled.
    push_exp(16'd100, 16'd1, 16'd2, 16'd3, 16'd4, 4);
    do_start(16'd100);
    start = 1'b1; bias = 16'd5;
    @(negedge clk);
    start = 1'b0;
    feed4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    start = 1'b1; bias = 16'd9;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done_hold", {31'd0, out_valid}, 32'd1);
    collect("t5", 0);
    @(negedge clk);
    chk("t5_no_queued_start", {31'd0, busy}, 32'd0);

    // Test 6: N_INPUTS=1, result two cycles after start.
    start1 = 1'b1; bias1 = 16'd7;
    @(negedge clk);
    start1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'd8;
    chk("t6_in_ready", {31'd0, in_ready1}, 32'd1);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("t6_valid", {31'd0, out_valid1}, 32'd1);
    chk("t6_data", {16'd0, out_data1}, 32'd15);
    chk("t6_ovf", {31'd0, out_ovf1}, 32'd0);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("t6_idle", {31'd0, busy1}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
